// File: rtl/smem_pkg.sv
// Shared definitions for the SMEM output writer slice.
//   LINE_W        : width of one upstream result line / host cache line
//   state_t       : writer FSM encoding (also driven on the debug state port)
//   HDR_*         : field offsets inside a header line, for benches and checkers
package smem_pkg;

  localparam int LINE_W = 512;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_REQ = 3'd1,
    ST_STREAM   = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Header line layout: read count, mem group size, return code.
  localparam int HDR_READ_NUM_LSB = 0;
  localparam int HDR_READ_NUM_W   = 10;
  localparam int HDR_MEM_SIZE_LSB = 64;
  localparam int HDR_MEM_SIZE_W   = 7;
  localparam int HDR_RET_LSB      = 128;
  localparam int HDR_RET_W        = 32;

endpackage

// File: rtl/smem_output_writer_if.sv
// Upstream result channel and host write channel of the SMEM output writer.
//   up_output_*  : permit/request grant, line data, valid and sticky finish
//   stall_out    : registered back-pressure to the upstream pipeline
//   wr_req_*     : write request channel to the host result buffer
//   wr_rsp_valid : one pulse per acknowledged write
// Modports: master = the writer, slave = upstream source plus host.
//
// Handshake rules: a write request transfers on a cycle where wr_req_valid
// and wr_req_ready are both high; once valid is raised, valid, addr and data
// stay unchanged until that transfer, and ready may depend on nothing but the
// host. An upstream line transfers on a cycle where up_output_valid is high
// and stall_out is low while up_output_permit is high; there is no ready.
interface smem_output_writer_if #(
  parameter int ADDR_WIDTH = 42
);
  logic                        up_output_request;
  logic                        up_output_permit;
  logic [smem_pkg::LINE_W-1:0] up_output_data;
  logic                        up_output_valid;
  logic                        up_output_finish;
  logic                        stall_out;
  logic                        wr_req_valid;
  logic                        wr_req_ready;
  logic [ADDR_WIDTH-1:0]       wr_req_addr;
  logic [smem_pkg::LINE_W-1:0] wr_req_data;
  logic                        wr_rsp_valid;

  modport master (
    input  up_output_request, up_output_data, up_output_valid, up_output_finish,
    input  wr_req_ready, wr_rsp_valid,
    output up_output_permit, stall_out, wr_req_valid, wr_req_addr, wr_req_data
  );

  modport slave (
    output up_output_request, up_output_data, up_output_valid, up_output_finish,
    output wr_req_ready, wr_rsp_valid,
    input  up_output_permit, stall_out, wr_req_valid, wr_req_addr, wr_req_data
  );
endinterface

// File: rtl/smem_line_fifo.sv
// Synchronous first-word-fall-through line buffer.
//   push/push_data : enqueue; dropped when full unless a pop happens the same cycle
//   pop            : dequeue the head; ignored when empty
//   head           : current head entry (storage is registered, so a word pushed
//                    at one edge is visible on head after that edge)
//   full/empty/count : occupancy status
module smem_line_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // Read-first: a pop frees the slot the push lands in, so full+pop still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/smem_output_writer.sv
// Writes upstream SMEM result lines to consecutive host cache lines.
//   clk, reset        : clock, asynchronous active-high reset
//   start, base_addr  : begin a batch at base_addr (honoured in IDLE/DONE only)
//   bus               : upstream result channel + host write channel
//   lines_written     : write responses counted this batch
//   batch_done        : high in DONE until the next start
//   overflow_err      : sticky, a line arrived while the buffer was full
//   dbg_state         : current FSM state
module smem_output_writer import smem_pkg::*; #(
  parameter int ADDR_WIDTH      = 42,
  parameter int FIFO_DEPTH      = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  smem_output_writer_if.master  bus,
  output logic [CNT_WIDTH-1:0]  lines_written,
  output logic                  batch_done,
  output logic                  overflow_err,
  output state_t                dbg_state
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [CNT_WIDTH-1:0]  outstanding_q;
  logic                  stall_q;
  logic                  overflow_q;
  logic                  permit_c;
  logic                  done_c;

  logic                  fifo_full, fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic [LINE_W-1:0]     fifo_head;

  logic                  start_ok, line_in, req_valid, issue, rsp_ok;

  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign line_in   = (state_q == ST_STREAM) && bus.up_output_valid && !stall_q;
  assign req_valid = !fifo_empty && (outstanding_q < CNT_WIDTH'(MAX_OUTSTANDING));
  assign issue     = req_valid && bus.wr_req_ready;
  // Stray acknowledgements with nothing outstanding are ignored.
  assign rsp_ok    = bus.wr_rsp_valid && (outstanding_q != '0);

  smem_line_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (line_in),
    .push_data (bus.up_output_data),
    .pop       (issue),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    permit_c = 1'b0;
    done_c   = 1'b0;
    unique case (state_q)
      ST_IDLE:     if (start) state_d = ST_WAIT_REQ;
      ST_WAIT_REQ: if (bus.up_output_request) state_d = ST_STREAM;
      ST_STREAM: begin
        permit_c = 1'b1;
        if (bus.up_output_finish && !stall_q) state_d = ST_DRAIN;
      end
      ST_DRAIN:    if (fifo_empty && outstanding_q == '0) state_d = ST_DONE;
      ST_DONE: begin
        done_c = 1'b1;
        if (start) state_d = ST_WAIT_REQ;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
      lines_written <= '0;
      stall_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Sampled occupancy; two spare slots absorb the line accepted while
      // this register catches up.
      stall_q <= (fifo_count >= FCW'(FIFO_DEPTH - 2));
      if (line_in && fifo_full && !issue) overflow_q <= 1'b1;
      if (start_ok) begin
        base_q        <= base_addr;
        issued_q      <= '0;
        outstanding_q <= '0;
        lines_written <= '0;
      end else begin
        if (issue)  issued_q      <= issued_q + CNT_WIDTH'(1);
        if (rsp_ok) lines_written <= lines_written + CNT_WIDTH'(1);
        case ({issue, rsp_ok})
          2'b10:   outstanding_q <= outstanding_q + CNT_WIDTH'(1);
          2'b01:   outstanding_q <= outstanding_q - CNT_WIDTH'(1);
          default: outstanding_q <= outstanding_q;
        endcase
      end
    end
  end

  assign bus.up_output_permit = permit_c;
  assign bus.stall_out        = stall_q;
  assign bus.wr_req_valid     = req_valid;
  // Address wraps naturally at ADDR_WIDTH bits.
  assign bus.wr_req_addr      = base_q + ADDR_WIDTH'(issued_q);
  // Masked so stale buffer contents never show after a reset.
  assign bus.wr_req_data      = req_valid ? fifo_head : '0;
  assign batch_done           = done_c;
  assign overflow_err         = overflow_q;
  assign dbg_state            = state_q;
endmodule

// File: tb/tb_smem_output_writer.sv
module tb_smem_output_writer;
  import smem_pkg::*;

  localparam int ADDR_WIDTH      = 42;
  localparam int FIFO_DEPTH      = 16;
  localparam int CNT_WIDTH       = 16;
  localparam int MAX_OUTSTANDING = 32;
  localparam int SB_W            = ADDR_WIDTH + LINE_W;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] base_addr = '0;
  logic [CNT_WIDTH-1:0]  lines_written;
  logic                  batch_done;
  logic                  overflow_err;
  state_t                dbg_state;

  always #5 clk = ~clk;

  smem_output_writer_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  smem_output_writer #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .CNT_WIDTH       (CNT_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .bus           (bus),
    .lines_written (lines_written),
    .batch_done    (batch_done),
    .overflow_err  (overflow_err),
    .dbg_state     (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [SB_W-1:0]       exp_q[$];
  int                    rsp_due[$];
  int                    cyc = 0;
  int                    n_vec = 0;
  int                    n_fail = 0;
  int                    issued_n = 0;
  int                    acked_n = 0;
  int                    model_out = 0;
  logic                  rsp_auto = 1'b1;
  logic                  rsp_manual = 1'b0;
  logic [ADDR_WIDTH-1:0] addr_model;
  logic [ADDR_WIDTH-1:0] last_addr = '0;
  int                    sent_n = 0;
  bit                    stall_seen = 0;
  int                    sent_at_stall = 0;
  logic                  prev_hold = 1'b0;
  logic [ADDR_WIDTH-1:0] prev_addr;
  logic [LINE_W-1:0]     prev_data;
  logic [SB_W-1:0]       exp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Host side: acknowledgements two cycles after a transfer, or manual pulses.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (reset) begin
      bus.wr_rsp_valid = 1'b0;
    end else if (rsp_manual ||
                 (rsp_auto && rsp_due.size() > 0 && rsp_due[0] <= cyc)) begin
      bus.wr_rsp_valid = 1'b1;
      if (rsp_due.size() > 0) void'(rsp_due.pop_front());
    end else begin
      bus.wr_rsp_valid = 1'b0;
    end
  end

  // Monitor: sampled mid-cycle, all inputs change just after the rising edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("req_hold_valid", 64'(bus.wr_req_valid), 64'd1);
        check("req_hold_addr", 64'(bus.wr_req_addr), 64'(prev_addr));
        check("req_hold_data", 64'(bus.wr_req_data != prev_data), 64'd0);
      end
      if (bus.wr_rsp_valid && model_out > 0) begin
        acked_n++;
        model_out--;
      end
      if (bus.wr_req_valid && bus.wr_req_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: write to addr %0h, expected no write", bus.wr_req_addr);
        end else begin
          exp_e = exp_q.pop_front();
          if ({bus.wr_req_addr, bus.wr_req_data} !== exp_e) begin
            n_fail++;
            $display("FAIL wr_line: got addr %0h data[63:0] %0h, expected addr %0h data[63:0] %0h",
                     bus.wr_req_addr, bus.wr_req_data[63:0],
                     exp_e[SB_W-1 -: ADDR_WIDTH], exp_e[63:0]);
          end
        end
        last_addr = bus.wr_req_addr;
        issued_n++;
        model_out++;
        rsp_due.push_back(cyc + 2);
      end
      prev_hold = bus.wr_req_valid && !bus.wr_req_ready;
      prev_addr = bus.wr_req_addr;
      prev_data = bus.wr_req_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [LINE_W-1:0] make_line(input int idx, input int pat);
    logic [LINE_W-1:0] l;
    l = '0;
    if (idx == 0) begin
      l[HDR_READ_NUM_LSB +: HDR_READ_NUM_W] = HDR_READ_NUM_W'($urandom_range(1, 1023));
      l[HDR_MEM_SIZE_LSB +: HDR_MEM_SIZE_W] = HDR_MEM_SIZE_W'($urandom_range(0, 127));
      l[HDR_RET_LSB +: HDR_RET_W]           = $urandom;
    end else if (pat == 1 && (idx % 2) == 0) begin
      l = '0;  // gap line between mem groups
    end else begin
      for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = $urandom;
    end
    return l;
  endfunction

  task automatic start_batch(input logic [ADDR_WIDTH-1:0] base);
    int g;
    issued_n = 0;
    acked_n = 0;
    sent_n = 0;
    stall_seen = 0;
    addr_model = base;
    base_addr = base;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_clears_done", 64'(batch_done), 64'd0);
    check("start_clears_count", 64'(lines_written), 64'd0);
    bus.up_output_request = 1'b1;
    g = 0;
    while (!bus.up_output_permit && g < 50) begin
      step();
      g++;
    end
    check("permit_granted", 64'(bus.up_output_permit), 64'd1);
  endtask

  task automatic send_line(input logic [LINE_W-1:0] d);
    int g;
    g = 0;
    while (bus.stall_out && g < 300) begin
      if (!stall_seen) begin
        stall_seen = 1;
        sent_at_stall = sent_n;
      end
      step();
      g++;
    end
    if (g >= 300) check("stall_release", 64'(bus.stall_out), 64'd0);
    bus.up_output_valid = 1'b1;
    bus.up_output_data = d;
    exp_q.push_back({addr_model, d});
    addr_model = addr_model + ADDR_WIDTH'(1);
    sent_n++;
    step();
    bus.up_output_valid = 1'b0;
    bus.up_output_data = '0;
  endtask

  task automatic finish_and_wait(input int n);
    int g;
    bus.up_output_finish = 1'b1;
    g = 0;
    while (!batch_done && g < 3000) begin
      step();
      g++;
    end
    check("batch_done", 64'(batch_done), 64'd1);
    check("done_after_all_acks", 64'(acked_n), 64'(n));
    check("lines_written", 64'(lines_written), 64'(n));
    check("all_lines_written", 64'(exp_q.size()), 64'd0);
    bus.up_output_finish = 1'b0;
    bus.up_output_request = 1'b0;
  endtask

  task automatic run_batch(input logic [ADDR_WIDTH-1:0] base, input int n, input int pat);
    start_batch(base);
    for (int i = 0; i < n; i++) send_line(make_line(i, pat));
    finish_and_wait(n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_permit"}, 64'(bus.up_output_permit), 64'd0);
    check({tag, "_stall"}, 64'(bus.stall_out), 64'd0);
    check({tag, "_req_valid"}, 64'(bus.wr_req_valid), 64'd0);
    check({tag, "_req_addr"}, 64'(bus.wr_req_addr), 64'd0);
    check({tag, "_req_data"}, 64'(bus.wr_req_data != '0), 64'd0);
    check({tag, "_lines_written"}, 64'(lines_written), 64'd0);
    check({tag, "_batch_done"}, 64'(batch_done), 64'd0);
    check({tag, "_overflow"}, 64'(overflow_err), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [ADDR_WIDTH-1:0] base;
    int                    nlines;
    int                    pat;
    int                    exp_lines;
    logic [ADDR_WIDTH-1:0] exp_last_addr;
  } batch_vec_t;

  batch_vec_t vecs[4];

  initial begin
    bus.up_output_request = 1'b0;
    bus.up_output_data    = '0;
    bus.up_output_valid   = 1'b0;
    bus.up_output_finish  = 1'b0;
    bus.wr_req_ready      = 1'b1;
    bus.wr_rsp_valid      = 1'b0;

    // header + 3 data lines; empty batch; address wrap; batch with zero gap lines
    vecs[0] = '{base: 42'h1000,        nlines: 4, pat: 0, exp_lines: 4, exp_last_addr: 42'h1003};
    vecs[1] = '{base: 42'h800,         nlines: 0, pat: 0, exp_lines: 0, exp_last_addr: 42'h0};
    vecs[2] = '{base: 42'h3FFFFFFFFFE, nlines: 4, pat: 0, exp_lines: 4, exp_last_addr: 42'h1};
    vecs[3] = '{base: 42'h40,          nlines: 6, pat: 1, exp_lines: 6, exp_last_addr: 42'h45};

    step(3);
    check_all_zero("reset");
    reset = 1'b0;
    step(2);

    for (int v = 0; v < 4; v++) begin
      start_batch(vecs[v].base);
      for (int i = 0; i < vecs[v].nlines; i++) send_line(make_line(i, vecs[v].pat));
      finish_and_wait(vecs[v].exp_lines);
      check("vec_issued", 64'(issued_n), 64'(vecs[v].exp_lines));
      if (vecs[v].nlines > 0) check("vec_last_addr", 64'(last_addr), 64'(vecs[v].exp_last_addr));
    end

    // Back-pressure: host stalls 40 cycles while upstream streams continuously.
    bus.wr_req_ready = 1'b0;
    start_batch(42'h5000);
    fork
      begin
        step(40);
        bus.wr_req_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 30; i++) send_line(make_line(i, 0));
      end
    join
    check("bp_stall_seen", 64'(stall_seen), 64'd1);
    check("bp_stall_margin", 64'(sent_at_stall >= FIFO_DEPTH - 2 && sent_at_stall <= FIFO_DEPTH - 1), 64'd1);
    check("bp_no_overflow", 64'(overflow_err), 64'd0);
    finish_and_wait(30);

    // Outstanding cap with responses withheld.
    bus.wr_req_ready = 1'b1;
    rsp_auto = 1'b0;
    start_batch(42'h9000);
    for (int i = 0; i < 40; i++) send_line(make_line(i, 0));
    bus.up_output_finish = 1'b1;
    step(20);
    check("cap_issued", 64'(issued_n), 64'(MAX_OUTSTANDING));
    check("cap_valid_low", 64'(bus.wr_req_valid), 64'd0);
    check("cap_no_writes_acked", 64'(lines_written), 64'd0);
    rsp_manual = 1'b1;
    step();
    rsp_manual = 1'b0;
    step(10);
    check("cap_one_more_issued", 64'(issued_n), 64'd33);
    check("cap_one_acked", 64'(lines_written), 64'd1);
    // Bring outstanding down to 31 with the host stalled.
    bus.wr_req_ready = 1'b0;
    step(2);
    rsp_manual = 1'b1;
    step();
    rsp_manual = 1'b0;
    step(3);
    check("cap_31_issued", 64'(issued_n), 64'd33);
    check("cap_31_acked", 64'(lines_written), 64'd2);
    // Issue and response in the same cycle at 31: stays 31, so one more issue follows.
    bus.wr_req_ready = 1'b1;
    rsp_manual = 1'b1;
    step();
    rsp_manual = 1'b0;
    step(10);
    check("same_cycle_issued", 64'(issued_n), 64'd35);
    check("same_cycle_acked", 64'(lines_written), 64'd3);
    rsp_auto = 1'b1;
    finish_and_wait(40);

    // Reset in the middle of a stream, then restart at a new base.
    bus.wr_req_ready = 1'b0;
    start_batch(42'h3000);
    for (int i = 0; i < 5; i++) send_line(make_line(i, 0));
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    rsp_due.delete();
    model_out = 0;
    bus.up_output_request = 1'b0;
    bus.wr_req_ready = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    run_batch(42'h2000, 3, 0);
    check("restart_last_addr", 64'(last_addr), 64'h2002);
    check("restart_issued", 64'(issued_n), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/smem_output_writer.md
Name: smem_output_writer

Overview:
- Downstream consumer of the SMEM result/mem-queue stage: takes the 512-bit output lines that stage emits after a batch completes and writes them as consecutive cache lines to a host result buffer.
- Grants the upstream output permission, applies back-pressure through the shared pipeline stall, and buffers lines in a small FIFO.
- Counts write responses and signals batch completion once every line is acknowledged.

Parameters:
- ADDR_WIDTH, 42, host cache-line address width.
- FIFO_DEPTH, 16, line buffer depth; power of two, at least 8.
- CNT_WIDTH, 16, width of line and outstanding-write counters.
- MAX_OUTSTANDING, 32, maximum issued-but-unacknowledged writes.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; latches base_addr and begins a batch
- base_addr  in  ADDR_WIDTH  cache-line address of first result line
- up_output_request  in  1  upstream has results ready
- up_output_permit  out  1  grant to upstream
- up_output_data  in  512  upstream result line
- up_output_valid  in  1  line valid; qualified by !stall_out
- up_output_finish  in  1  upstream has emitted its last line (sticky)
- stall_out  out  1  global pipeline stall driven to upstream
- wr_req_valid  out  1  write request
- wr_req_ready  in  1  host accepts request
- wr_req_addr  out  ADDR_WIDTH  line address
- wr_req_data  out  512  line data
- wr_rsp_valid  in  1  one write acknowledged
- lines_written  out  CNT_WIDTH  lines acknowledged this batch
- batch_done  out  1  level; all lines acknowledged
- overflow_err  out  1  sticky; line arrived while FIFO full

Behaviour:
- Reset (async, any time, including mid-batch): all outputs 0, FSM to IDLE, FIFO empty, counters 0. Lines in flight are dropped.
- FSM states IDLE, WAIT_REQ, STREAM, DRAIN, DONE.
  - IDLE: start -> WAIT_REQ; latch base_addr, clear counters, clear batch_done.
  - WAIT_REQ: up_output_request=1 -> STREAM; up_output_permit goes 1 on the next cycle.
  - STREAM: up_output_permit=1. Accept a line when up_output_valid && !stall_out. Go to DRAIN when up_output_finish && !stall_out.
  - DRAIN: up_output_permit=0. Leave when the FIFO is empty and outstanding==0 -> DONE.
  - DONE: batch_done=1 until next start, which restarts as in IDLE.
  - start outside IDLE/DONE is ignored.
- Upstream lines with all 512 bits zero are gaps between mem groups. They are still written; no filtering.
- Back-pressure: stall_out is a register, set when FIFO occupancy >= FIFO_DEPTH-2 at the clock edge, else 0. The 2-entry margin covers the one-cycle register lag.
- Overflow: a qualified line arriving while the FIFO is full is discarded and sets overflow_err. This cannot happen under correct operation.
- Write issue:
  - wr_req_valid = FIFO non-empty && outstanding < MAX_OUTSTANDING.
  - wr_req_data = FIFO head; wr_req_addr = base + issued_count.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - A transfer occurs on wr_req_valid && wr_req_ready: pop FIFO, issued_count+1, outstanding+1.
  - Request fields are held stable while valid && !ready.
- Responses: each wr_rsp_valid decrements outstanding and increments lines_written.
  - Same-cycle issue and response leave outstanding unchanged.
  - A response with outstanding==0 is ignored.
- FIFO push and pop in the same cycle are allowed at any occupancy except push-when-full, which takes the overflow path. Read-first, so a full FIFO with a simultaneous pop accepts the push.
- Latency: a line accepted at cycle N is presented on wr_req at N+1 at the earliest (registered FIFO output).

Decomposition:
- Shared package smem_pkg holds:
  - LINE_W=512.
  - FSM state typedef.
  - Header-line field offsets (read num [9:0], mem size [70:64], ret [159:128]) for use by benches and checkers.
- One sub-module: smem_line_fifo, a synchronous FIFO (push, pop, full, empty, count, first-word-fall-through), instantiated once.

Test Plan:
- Basic: base_addr=0x1000, upstream sends header plus 3 data lines plus finish, wr_req_ready=1, responses 2 cycles later -> addresses 0x1000..0x1003 in order, lines_written=4, batch_done rises after the 4th response.
- Back-pressure: FIFO_DEPTH=16, wr_req_ready=0 for 40 cycles, upstream streams continuously -> stall_out rises once occupancy reaches 14, overflow_err stays 0; all lines written in order after ready returns.
- Outstanding cap: responses withheld, 40 lines queued -> exactly 32 requests issued. One response -> exactly one more request issued.
- Zero-result batch: up_output_request then immediate finish with no valid lines -> no writes, lines_written=0, batch_done=1.
- Reset mid-STREAM after 5 lines: all outputs 0 immediately. A new start with base 0x2000 writes from 0x2000.
- Same-cycle issue and response at outstanding=31 -> outstanding stays 31, lines_written increments by 1.
